// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state enum, opcodes, mux codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_BNE    = 4'd12,
    S_UNUSED13 = 4'd13,
    S_UNUSED14 = 4'd14,
    S_HALT   = 4'd15
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore output decode for the control FSM; only pc_en in the branch
// states looks at zero. State 12 decodes only when MC_BNE_EN is defined.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  mc_state_t  state,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       halted
);

  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_source  = PCSRC_ALU;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_en      = ~zero;
        instr_done = 1'b1;
      end
`endif
      S_JUMP: begin
        pc_en      = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: state register, next-state logic and reset gating.
// Optional bne support is enabled by defining MC_BNE_EN.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  mc_state_t state_q, state_d;
  // Remembers lw vs sw from DECODE so opcode is never looked at after dispatch.
  logic      store_q, store_d;

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW: begin
            state_d = S_MEMADR;
            store_d = 1'b0;
          end
          OP_SW: begin
            state_d = S_MEMADR;
            store_d = 1'b1;
          end
          OP_RTYPE: state_d = S_EXEC;
          OP_BEQ:   state_d = S_BEQ;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_ADDIEX;
`ifdef MC_BNE_EN
          OP_BNE:   state_d = S_BNE;
`endif
          default:  state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RWB, S_BEQ, S_JUMP, S_ADDIWB: state_d = S_FETCH;
`ifdef MC_BNE_EN
      S_BNE:    state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  logic dec_pc_en, dec_mem_read, dec_mem_write, dec_ir_write;
  logic dec_reg_write, dec_instr_done, dec_halted;

  mc_ctrl_decode u_decode (
    .state      (state_q),
    .zero       (zero),
    .pc_en      (dec_pc_en),
    .iord       (iord),
    .mem_read   (dec_mem_read),
    .mem_write  (dec_mem_write),
    .ir_write   (dec_ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (dec_reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .instr_done (dec_instr_done),
    .halted     (dec_halted)
  );

  // State reads as FETCH during reset, so its enables must be masked explicitly.
  assign pc_en      = dec_pc_en      & ~rst;
  assign mem_read   = dec_mem_read   & ~rst;
  assign mem_write  = dec_mem_write  & ~rst;
  assign ir_write   = dec_ir_write   & ~rst;
  assign reg_write  = dec_reg_write  & ~rst;
  assign instr_done = dec_instr_done & ~rst;
  assign halted     = dec_halted     & ~rst;
  assign state      = state_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control unit for the multicycle MIPS CPU. It sequences the shared datapath: PC register, unified instruction/data memory, instruction register, register file, and the single ALU. It runs one Moore state machine per instruction. It reports its current state on the CPU's 4-bit `STATE` output, and the bench uses that output to track progress through the bubble-sort program.

## Interface
Parameters
- none (all encodings fixed in `mc_pkg`)

Ports
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `opcode` in 6: IR[31:26], stable outside FETCH
- `zero` in 1: ALU zero flag
- `pc_en` out 1: PC load enable (already merged with branch condition)
- `iord` out 1: memory address source; 0=PC, 1=ALUOut
- `mem_read` out 1: memory read enable
- `mem_write` out 1: memory write enable
- `ir_write` out 1: IR load enable
- `mem_to_reg` out 1: write-back source; 1=MDR, 0=ALUOut
- `reg_dst` out 1: destination register; 1=rd, 0=rt
- `reg_write` out 1: register file write enable
- `alu_src_a` out 1: 0=PC, 1=A
- `alu_src_b` out 2: 00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- `alu_op` out 2: 00=add, 01=sub, 10=funct
- `pc_source` out 2: 00=ALU result, 01=ALUOut, 10=jump target
- `instr_done` out 1: high in the final cycle of each instruction
- `halted` out 1: an illegal opcode was trapped
- `state` out 4: current state encoding

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- State encodings and asserted outputs (any output not listed is 0):
  - 0 FETCH: mem_read, ir_write, pc_en, alu_src_b=01. Next state is 1.
  - 1 DECODE: alu_src_b=11. Dispatch on `opcode`:
    - lw/sw→2, R→6, beq→8, j→9, addi→10, bne→12
    - any other opcode→15
  - 2 MEMADR: alu_src_a, alu_src_b=10. lw→3, sw→5.
  - 3 MEMRD: mem_read, iord. Next state is 4.
  - 4 MEMWB: reg_write, mem_to_reg, instr_done. Next state is 0.
  - 5 MEMWR: mem_write, iord, instr_done. Next state is 0.
  - 6 EXEC: alu_src_a, alu_op=10. Next state is 7.
  - 7 RWB: reg_write, reg_dst, instr_done. Next state is 0.
  - 8 BEQ: alu_src_a, alu_op=01, pc_source=01, pc_en=zero, instr_done. Next state is 0.
  - 9 JUMP: pc_en, pc_source=10, instr_done. Next state is 0.
  - 10 ADDIEX: alu_src_a, alu_src_b=10. Next state is 11.
  - 11 ADDIWB: reg_write, instr_done. Next state is 0.
  - 12 BNE: as state 8, but pc_en=~zero.
  - 15 HALT: halted=1, all enables 0. Stays in 15 until `rst`.
- Unused encodings 13 and 14 go to 15 on the next edge.
- Cycle counts: lw 5; sw, R-type, addi 4; beq, bne, j 3.

## Timing
- All outputs are decoded from the state register only, except `pc_en` in states 8 and 12, which also depends combinationally on `zero`.
- `opcode` is sampled only at the DECODE→next transition. It is a don't-care in every other state.
- While `rst`=1:
  - `state`=0
  - pc_en, mem_read, mem_write, ir_write, reg_write, instr_done and halted are all forced to 0
  - the mux selects take their FETCH values
- The first rising edge after `rst` deasserts completes FETCH.
- Reset asserted mid-instruction:
  - `state` goes to 0 immediately, without waiting for a clock edge.
  - A memory or register write whose state was interrupted does not occur after release.
- HALT is left only through reset. `halted` clears asynchronously with `rst`.

## Configuration
- `MC_BNE_EN` defined: opcode 000101 dispatches to state 12, with the behaviour above.
- `MC_BNE_EN` undefined: state 12 is not generated. Opcode 000101 dispatches to 15 (HALT), and encoding 12 is treated as unused (goes to 15).

## Structure
- `mc_pkg` holds:
  - the `mc_state_t` enum with the fixed 4-bit encodings above
  - opcode localparams (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_ADDI`, `OP_J`)
  - the `alu_op`, `alu_src_b` and `pc_source` code constants
- One sub-module, `mc_ctrl_decode`: purely combinational, mapping state (and `zero`) to outputs.
- The top level of `mc_control_fsm` holds the state register and the next-state logic.

## Test plan
- Reset then release, `opcode`=000000 → state sequence 0,1,6,7,0. `reg_write`=`reg_dst`=1 only in state 7. `instr_done` is high for exactly 1 cycle.
- `opcode`=100011 (lw) → sequence 0,1,2,3,4. `iord`=1 in state 3. `mem_to_reg`=`reg_write`=1 in state 4. 5 cycles total.
- `opcode`=000100, `zero`=1 then repeated with `zero`=0 → in state 8, `pc_en`=1 then 0. `pc_source`=01 and `alu_op`=01 in both runs.
- `opcode`=000101 with `MC_BNE_EN` defined, `zero`=0 → `pc_en`=1 in state 12. Same stimulus without the macro → state 15, `halted`=1, held for 10+ cycles.
- `opcode`=111111 → state 15, all enables stay 0. Assert `rst` → `state`=0 and `halted`=0 before the next clock edge.
- `rst` pulsed asynchronously during state 5 (sw) → `mem_write` drops at once, `state`=0. After release, normal FETCH with no stray write.
